// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with per-register rename busy/tag, registered read ports, commit extension and flush.
module rename_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int IDX_W = 5,
  parameter int TAG_W = 4,
  parameter int NREAD = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREAD-1:0]       rd_req_i,
  input  logic [NREAD*IDX_W-1:0] rd_idx_i,
  output logic [NREAD-1:0]       rd_valid_o,
  output logic [NREAD*XLEN-1:0]  rd_data_o,
  output logic [NREAD-1:0]       rd_busy_o,
  output logic [NREAD*TAG_W-1:0] rd_tag_o,
  input  logic                   alloc_en_i,
  input  logic [IDX_W-1:0]       alloc_idx_i,
  input  logic [TAG_W-1:0]       alloc_tag_i,
  input  logic                   commit_en_i,
  input  logic [IDX_W-1:0]       commit_idx_i,
  input  logic [TAG_W-1:0]       commit_tag_i,
  input  logic [XLEN-1:0]        commit_data_i,
  input  logic                   commit_ext_i,
  input  logic [2:0]             commit_size_i,
  input  logic                   flush_i
);
  logic [XLEN-1:0]  regs [NREG];
  logic [TAG_W-1:0] tags [NREG];
  logic [NREG-1:0]  busy;
  logic [XLEN-1:0]  ext_data;
  logic             cwr, cclr, awr;
  logic [XLEN-1:0]  r_data [NREAD];
  logic [TAG_W-1:0] r_tag [NREAD];
  logic [NREAD-1:0] r_busy;
  always_comb begin
    ext_data = !commit_ext_i            ? commit_data_i :
               commit_size_i == 3'b000 ? XLEN'($signed(commit_data_i[7:0])) :
               commit_size_i == 3'b001 ? XLEN'($signed(commit_data_i[15:0])) :
               commit_size_i == 3'b010 ? XLEN'($signed(commit_data_i[31:0])) :
               commit_size_i == 3'b100 ? XLEN'(commit_data_i[7:0]) :
               commit_size_i == 3'b101 ? XLEN'(commit_data_i[15:0]) : commit_data_i;
  end
  assign cwr  = commit_en_i && commit_idx_i != '0;
  assign cclr = cwr && busy[commit_idx_i] && tags[commit_idx_i] == commit_tag_i;
  assign awr  = alloc_en_i && alloc_idx_i != '0 && !flush_i;
  // reads see the commit's data and busy clear, but not a same-cycle alloc
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [IDX_W-1:0] i;
    assign i         = rd_idx_i[p*IDX_W +: IDX_W];
    assign r_data[p] = i == '0 ? '0 : (cwr && i == commit_idx_i) ? ext_data : regs[i];
    assign r_busy[p] = !flush_i && i != '0 && busy[i] && !(cclr && i == commit_idx_i);
    assign r_tag[p]  = r_busy[p] ? tags[i] : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        tags[r] <= '0;
      end
      busy       <= '0;
      rd_valid_o <= '0;
      rd_data_o  <= '0;
      rd_busy_o  <= '0;
      rd_tag_o   <= '0;
    end else begin
      if (cwr) regs[commit_idx_i] <= ext_data;
      if (flush_i) begin
        busy <= '0;
        for (int r = 0; r < NREG; r++) tags[r] <= '0;
      end else begin
        if (cclr) begin
          busy[commit_idx_i] <= 1'b0;
          tags[commit_idx_i] <= '0;
        end
        if (awr) begin
          busy[alloc_idx_i] <= 1'b1;
          tags[alloc_idx_i] <= alloc_tag_i;
        end
      end
      rd_valid_o <= rd_req_i;
      for (int q = 0; q < NREAD; q++) begin
        if (rd_req_i[q]) begin
          rd_data_o[q*XLEN +: XLEN]   <= r_data[q];
          rd_busy_o[q]                <= r_busy[q];
          rd_tag_o[q*TAG_W +: TAG_W]  <= r_tag[q];
        end
      end
    end
  end
endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed plus random stimulus checked against an array-based model of the register file.
module tb_rename_regfile;
  logic        clk = 0;
  logic        rst_n;
  logic [1:0]  rd_req;
  logic [9:0]  rd_idx;
  logic [1:0]  rd_valid;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [7:0]  rd_tag;
  logic        alloc_en;
  logic [4:0]  alloc_idx;
  logic [3:0]  alloc_tag;
  logic        commit_en;
  logic [4:0]  commit_idx;
  logic [3:0]  commit_tag;
  logic [31:0] commit_data;
  logic        commit_ext;
  logic [2:0]  commit_size;
  logic        flush;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_data [32];
  logic        m_busy [32];
  logic [3:0]  m_tag [32];
  logic        e_valid [2];
  logic [31:0] e_data [2];
  logic        e_busy [2];
  logic [3:0]  e_tag [2];

  rename_regfile dut (
    .clk(clk), .rst_n(rst_n), .rd_req_i(rd_req), .rd_idx_i(rd_idx),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_busy_o(rd_busy), .rd_tag_o(rd_tag),
    .alloc_en_i(alloc_en), .alloc_idx_i(alloc_idx), .alloc_tag_i(alloc_tag),
    .commit_en_i(commit_en), .commit_idx_i(commit_idx), .commit_tag_i(commit_tag),
    .commit_data_i(commit_data), .commit_ext_i(commit_ext), .commit_size_i(commit_size),
    .flush_i(flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ext_m(logic [31:0] d, logic e, logic [2:0] s);
    int unsigned b;
    if (!e) return d;
    case (s)
      3'd0: begin b = d % 256;   return b >= 128   ? b + 32'hFFFF_FF00 : b; end
      3'd1: begin b = d % 65536; return b >= 32768 ? b + 32'hFFFF_0000 : b; end
      3'd4: return d % 256;
      3'd5: return d % 65536;
      default: return d;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic idle();
    rd_req = 0; rd_idx = 0; alloc_en = 0; alloc_idx = 0; alloc_tag = 0;
    commit_en = 0; commit_idx = 0; commit_tag = 0; commit_data = 0;
    commit_ext = 0; commit_size = 0; flush = 0;
  endtask

  task automatic rd(logic [1:0] req, logic [4:0] i0, logic [4:0] i1);
    rd_req = req; rd_idx = {i1, i0};
  endtask

  task automatic cmt(logic [4:0] i, logic [3:0] t, logic [31:0] d, logic e, logic [2:0] s);
    commit_en = 1; commit_idx = i; commit_tag = t; commit_data = d; commit_ext = e; commit_size = s;
  endtask

  task automatic alc(logic [4:0] i, logic [3:0] t);
    alloc_en = 1; alloc_idx = i; alloc_tag = t;
  endtask

  // Model one clock edge, then compare every output a little after it.
  task automatic cycle();
    logic [4:0] i;
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin m_data[r] = 0; m_busy[r] = 0; m_tag[r] = 0; end
      for (int p = 0; p < 2; p++) begin e_valid[p] = 0; e_data[p] = 0; e_busy[p] = 0; e_tag[p] = 0; end
    end else begin
      if (commit_en && commit_idx != 0) begin
        m_data[commit_idx] = ext_m(commit_data, commit_ext, commit_size);
        if (m_busy[commit_idx] && m_tag[commit_idx] == commit_tag) begin
          m_busy[commit_idx] = 0; m_tag[commit_idx] = 0;
        end
      end
      if (flush) for (int r = 0; r < 32; r++) begin m_busy[r] = 0; m_tag[r] = 0; end
      for (int p = 0; p < 2; p++) begin
        e_valid[p] = rd_req[p];
        if (rd_req[p]) begin
          i = rd_idx[p*5 +: 5];
          e_data[p] = m_data[i];
          e_busy[p] = m_busy[i];
          e_tag[p]  = m_busy[i] ? m_tag[i] : 4'd0;
        end
      end
      if (alloc_en && alloc_idx != 0 && !flush) begin
        m_busy[alloc_idx] = 1; m_tag[alloc_idx] = alloc_tag;
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("valid%0d", p), 32'(rd_valid[p]), 32'(e_valid[p]));
      chk($sformatf("data%0d", p), rd_data[p*32 +: 32], e_data[p]);
      chk($sformatf("busy%0d", p), 32'(rd_busy[p]), 32'(e_busy[p]));
      chk($sformatf("tag%0d", p), 32'(rd_tag[p*4 +: 4]), 32'(e_tag[p]));
    end
  endtask

  initial begin
    idle();
    rst_n = 0;
    #2;
    cycle(); idle(); cycle();
    rst_n = 1;
    rd(2'b11, 5, 5); cycle(); idle(); cycle();
    cmt(3, 0, 32'h0000_00F0, 1, 3'b000); cycle(); idle(); rd(2'b01, 3, 0); cycle();
    idle(); cmt(3, 0, 32'h0000_00F0, 1, 3'b100); cycle(); idle(); rd(2'b10, 0, 3); cycle();
    idle(); cmt(3, 0, 32'h0001_8001, 1, 3'b101); cycle(); idle(); rd(2'b11, 3, 3); cycle();
    idle(); cmt(3, 0, 32'h8000_8001, 1, 3'b001); cycle(); idle(); rd(2'b01, 3, 0); cycle();
    idle(); alc(7, 3); cycle();
    idle(); cmt(7, 2, 32'h0000_0011, 0, 0); cycle();
    idle(); rd(2'b01, 7, 0); cycle();
    idle(); cmt(7, 3, 32'h0000_0022, 0, 0); rd(2'b10, 0, 7); cycle();
    idle(); rd(2'b11, 7, 7); cycle();
    idle(); alc(4, 1); cycle();
    idle(); cmt(4, 1, 32'h55, 0, 0); alc(4, 6); rd(2'b11, 4, 4); cycle();
    idle(); rd(2'b01, 4, 0); cycle();
    idle(); alc(2, 5); cycle(); idle(); alc(9, 7); cycle();
    idle(); flush = 1; alc(10, 2); cmt(9, 7, 32'hAB, 0, 0); rd(2'b11, 2, 9); cycle();
    idle(); rd(2'b11, 2, 9); cycle(); idle(); rd(2'b01, 10, 0); cycle();
    idle(); cmt(0, 0, 32'h123, 0, 0); alc(0, 4); rd(2'b11, 0, 0); cycle();
    idle(); rd(2'b11, 0, 0); cycle();
    idle(); alc(12, 9); cycle(); idle(); alc(13, 8); cycle();
    idle(); rst_n = 0; rd(2'b11, 12, 13); alc(14, 1); cycle();
    rst_n = 1; idle(); rd(2'b11, 12, 3); cycle();
    for (int n = 0; n < 400; n++) begin
      idle();
      rd_req      = 2'($urandom);
      rd_idx      = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      alloc_en    = ($urandom_range(0, 2) != 0);
      alloc_idx   = 5'($urandom_range(0, 15));
      alloc_tag   = 4'($urandom);
      commit_en   = ($urandom_range(0, 2) != 0);
      commit_idx  = 5'($urandom_range(0, 15));
      commit_tag  = 4'($urandom_range(0, 3));
      commit_data = $urandom;
      commit_ext  = 1'($urandom);
      commit_size = 3'($urandom);
      flush       = ($urandom_range(0, 29) == 0);
      rst_n       = ($urandom_range(0, 149) != 0);
      cycle();
    end
    rst_n = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised architectural register file with per-register rename status for the out-of-order core.
- Sits between decode/dispatch and the reservation stations.
- Provides NREAD registered read ports, each returning a value, or a busy flag plus the producing ROB tag.
- Accepts one dispatch rename allocation and one ROB commit per cycle; commit applies load sign/zero extension.
- Supports a global flush on mispredict.

Parameters:
- XLEN, 32, data width; must be >= 32.
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- IDX_W, 5, register index width; must equal clog2(NREG).
- TAG_W, 4, ROB tag width.
- NREAD, 2, number of read ports.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  synchronous active-low reset.
- rd_req_i  in  NREAD  per-port read request.
- rd_idx_i  in  NREAD*IDX_W  per-port register index; port p uses bits [p*IDX_W +: IDX_W].
- rd_valid_o  out  NREAD  per-port response valid.
- rd_data_o  out  NREAD*XLEN  per-port register value.
- rd_busy_o  out  NREAD  per-port flag: register awaits an in-flight producer.
- rd_tag_o  out  NREAD*TAG_W  per-port ROB tag of the producer; 0 when not busy.
- alloc_en_i  in  1  dispatch renames a destination register.
- alloc_idx_i  in  IDX_W  destination register index.
- alloc_tag_i  in  TAG_W  ROB tag assigned to that destination.
- commit_en_i  in  1  ROB retires a register write.
- commit_idx_i  in  IDX_W  destination register index.
- commit_tag_i  in  TAG_W  ROB tag of the retiring entry.
- commit_data_i  in  XLEN  raw result.
- commit_ext_i  in  1  1 = apply load extension selected by commit_size_i.
- commit_size_i  in  3  load funct3.
- flush_i  in  1  clear all rename state.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - all registers and busy bits cleared, all tags cleared.
  - rd_valid_o, rd_data_o, rd_busy_o and rd_tag_o all 0.
  - reset overrides every other input in that cycle.
- Read latency: exactly 1 cycle.
  - rd_req_i[p] high at edge N gives rd_valid_o[p]=1 during cycle N+1, with data, busy and tag sampled at edge N.
  - rd_valid_o[p] is 0 on the next cycle if not requested.
  - Data outputs hold their last value while valid is 0.
- Commit:
  - Extension when commit_ext_i=1:
    - 000: sign-extend bits [7:0].
    - 001: sign-extend bits [15:0].
    - 010: bits [31:0], sign-extended to XLEN.
    - 100: zero-extend bits [7:0].
    - 101: zero-extend bits [15:0].
    - any other code: raw commit_data_i.
  - When commit_ext_i=0, commit_data_i is written unmodified.
  - The data write is always performed.
  - busy is cleared only if busy=1 and the stored tag equals commit_tag_i; a stale commit leaves busy and tag untouched.
- Alloc: sets busy=1 and tag=alloc_tag_i for alloc_idx_i.
- Simultaneous commit and alloc to the same index: data is written; busy=1 and tag=alloc_tag_i (alloc wins).
- Read-during-commit bypass: a read of commit_idx_i in the commit cycle returns the extended commit data, with busy/tag as they are after the commit's clear.
- Read-during-alloc: a read of alloc_idx_i in the alloc cycle returns the pre-alloc busy/tag. Example: add x1,x1,x2 sees the old producer.
- Flush:
  - all busy bits and tags are cleared at the edge.
  - an alloc in the flush cycle is ignored.
  - a commit in the flush cycle still writes data.
  - reads in the flush cycle report busy=0 and tag=0.
- Register 0:
  - commit and alloc to index 0 are ignored.
  - reads of index 0 return data 0, busy 0, tag 0 on every port.
- Multiple ports reading the same index return identical results.

Test Plan:
- Reset, then read x5 on both ports → rd_valid_o=2'b11, data 0, busy 0, tag 0 one cycle later.
- Commit x3 with data 0x000000F0, ext=1, size=000 → a later read of x3 returns 0xFFFFFFF0; same with size=100 → 0x000000F0; size=101 with data 0x00018001 → 0x00008001.
- Alloc x7 with tag 3, then commit x7 with tag 2 → busy stays 1 with tag 3 and data is updated; commit x7 with tag 3 → busy 0.
- Same cycle: commit x4 (tag 1, data 0x55) and alloc x4 (tag 6), with a read of x4 → the read returns 0x55 with busy 0 (bypass); the next read returns 0x55, busy 1, tag 6.
- Alloc x2 and x9, then flush_i together with alloc x10 and commit x9 (data 0xAB) → afterwards x2/x9/x10 are not busy and x9=0xAB.
- Commit and alloc to x0, then read x0 → data 0, busy 0; assert rst_n=0 mid-sequence with busy registers → all cleared the next cycle.
